// File: rtl/ascon_serial_loader_pkg.sv
// ---------------------------------------------------------------------------
// ascon_serial_loader_pkg : shared widths, buffer select codes, FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ascon_serial_loader_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int IDX_W   = 2;

  localparam logic [1:0] SEL_KEY   = 2'd0;
  localparam logic [1:0] SEL_NONCE = 2'd1;
  localparam logic [1:0] SEL_AD    = 2'd2;
  localparam logic [1:0] SEL_DATA  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ascon_serial_loader_word_buf.sv
// ---------------------------------------------------------------------------
// ascon_serial_loader_word_buf : word-writable block register, MSB-first bit read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_serial_loader_word_buf #(
  parameter int BLOCK_W = ascon_serial_loader_pkg::BLOCK_W,
  parameter int WORD_W  = ascon_serial_loader_pkg::WORD_W,
  parameter int IDX_W   = ascon_serial_loader_pkg::IDX_W,
  parameter int CNT_W   = $clog2(BLOCK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic              rd_bit
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam logic [CNT_W-1:0] TOP_BIT = CNT_W'(BLOCK_W - 1);

  logic [BLOCK_W-1:0] q;

  // Word 0 is the most-significant word of the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (wr_idx == IDX_W'(w)) begin
          q[(NWORDS-1-w)*WORD_W +: WORD_W] <= wr_data;
        end
      end
    end
  end

  assign rd_bit = q[TOP_BIT - rd_idx];

endmodule

`default_nettype wire

// File: rtl/ascon_serial_loader.sv
// ---------------------------------------------------------------------------
// ascon_serial_loader : loads key/nonce/AD/data words and streams them to the
// serial Ascon core. Option macro: ASCON_LOADER_KEY_WIPE_EN (clear key after use)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_serial_loader #(
  parameter int BLOCK_W = ascon_serial_loader_pkg::BLOCK_W,
  parameter int WORD_W  = ascon_serial_loader_pkg::WORD_W,
  parameter int IDX_W   = ascon_serial_loader_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_sel_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              go_i,
  input  logic              decrypt_i,
  input  logic              core_ready_i,
  output logic              keyxSO,
  output logic              noncexSO,
  output logic              adxSO,
  output logic              dataxSO,
  output logic              startxSO,
  output logic              decryptxSO,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_err_o
);

  import ascon_serial_loader_pkg::*;

  localparam int CNT_W = $clog2(BLOCK_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             decrypt_q;
  logic             wr_err_q;
  logic             idle;
  logic             shifting;
  logic             key_wipe;
  logic [3:0]       buf_bit;

  assign idle     = (state == ST_IDLE);
  assign shifting = (state == ST_SHIFT);

`ifdef ASCON_LOADER_KEY_WIPE_EN
  assign key_wipe = (state == ST_START);
`else
  assign key_wipe = 1'b0;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_buf
    ascon_serial_loader_word_buf #(
      .BLOCK_W (BLOCK_W),
      .WORD_W  (WORD_W),
      .IDX_W   (IDX_W),
      .CNT_W   (CNT_W)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (key_wipe && (i == 0)),
      .wr_en   (wr_en_i && idle && (wr_sel_i == 2'(i))),
      .wr_idx  (wr_idx_i),
      .wr_data (wr_data_i),
      .rd_idx  (cnt),
      .rd_bit  (buf_bit[i])
    );
  end

  // The counter stops at CNT_LAST rather than wrapping so it stays put in START/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      decrypt_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_en_i && !idle;
      case (state)
        ST_IDLE: begin
          if (go_i) begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            decrypt_q <= decrypt_i;
          end
        end
        ST_SHIFT: begin
          if (cnt == CNT_LAST) state <= ST_START;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT:  if (core_ready_i) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign keyxSO     = shifting & buf_bit[SEL_KEY];
  assign noncexSO   = shifting & buf_bit[SEL_NONCE];
  assign adxSO      = shifting & buf_bit[SEL_AD];
  assign dataxSO    = shifting & buf_bit[SEL_DATA];
  assign startxSO   = (state == ST_START);
  assign decryptxSO = decrypt_q;
  assign busy_o     = !idle;
  assign done_o     = (state == ST_DONE);
  assign wr_err_o   = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_ascon_serial_loader : directed vector table plus hand-written corner runs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ascon_serial_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [1:0]  wr_sel_i;
  logic [1:0]  wr_idx_i;
  logic [31:0] wr_data_i;
  logic        go_i;
  logic        decrypt_i;
  logic        core_ready_i;
  logic        keyxSO, noncexSO, adxSO, dataxSO;
  logic        startxSO, decryptxSO, busy_o, done_o, wr_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [127:0] ad;
    logic [127:0] data;
    logic         dec;
    int           delay;
    bit           early;
  } vec_t;

  vec_t tbl [2];

  logic [127:0] ck, cn, ca, cd;
  logic [127:0] pk, pn, pa, pd;
  logic [127:0] kexp;
  int           bad;

  always #5 clk = ~clk;

  ascon_serial_loader dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en_i),
    .wr_sel_i     (wr_sel_i),
    .wr_idx_i     (wr_idx_i),
    .wr_data_i    (wr_data_i),
    .go_i         (go_i),
    .decrypt_i    (decrypt_i),
    .core_ready_i (core_ready_i),
    .keyxSO       (keyxSO),
    .noncexSO     (noncexSO),
    .adxSO        (adxSO),
    .dataxSO      (dataxSO),
    .startxSO     (startxSO),
    .decryptxSO   (decryptxSO),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wr_err_o     (wr_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [1:0] sel, input logic [1:0] idx, input logic [31:0] data);
    wr_en_i   = 1'b1;
    wr_sel_i  = sel;
    wr_idx_i  = idx;
    wr_data_i = data;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] n,
                      input logic [127:0] a, input logic [127:0] d);
    for (int i = 0; i < 4; i++) begin
      write_word(2'd0, 2'(i), k[127-32*i -: 32]);
      write_word(2'd1, 2'(i), n[127-32*i -: 32]);
      write_word(2'd2, 2'(i), a[127-32*i -: 32]);
      write_word(2'd3, 2'(i), d[127-32*i -: 32]);
    end
  endtask

  // One complete run from IDLE back to IDLE; the four streams are returned MSB-first.
  task automatic do_run(input logic dec, input int delay, input bit early, input int err_at,
                        input bit wr_same, input logic [31:0] wdata,
                        output logic [127:0] sk, output logic [127:0] sn,
                        output logic [127:0] sa, output logic [127:0] sd);
    int nbad;
    sk = '0; sn = '0; sa = '0; sd = '0; nbad = 0;
    go_i      = 1'b1;
    decrypt_i = dec;
    if (wr_same) begin
      wr_en_i   = 1'b1;
      wr_sel_i  = 2'd3;
      wr_idx_i  = 2'd0;
      wr_data_i = wdata;
    end
    tick();
    go_i      = 1'b0;
    wr_en_i   = 1'b0;
    decrypt_i = ~dec;
    check("busy_shift", busy_o, 1);
    if (early) core_ready_i = 1'b1;
    for (int k = 0; k < 128; k++) begin
      sk = {sk[126:0], keyxSO};
      sn = {sn[126:0], noncexSO};
      sa = {sa[126:0], adxSO};
      sd = {sd[126:0], dataxSO};
      if (startxSO || done_o || !busy_o) nbad++;
      if (err_at >= 0 && k == err_at + 1) begin
        check("wr_err_pulse", wr_err_o, 1);
        wr_en_i = 1'b0;
      end
      if (err_at >= 0 && k == err_at + 2) check("wr_err_clear", wr_err_o, 0);
      if (err_at >= 0 && k == err_at) begin
        wr_en_i   = 1'b1;
        wr_sel_i  = 2'd3;
        wr_idx_i  = 2'd0;
        wr_data_i = 32'hDEADBEEF;
      end
      tick();
    end
    check("shift_quiet", nbad, 0);
    check("start_pulse", startxSO, 1);
    check("decrypt_out", decryptxSO, dec);
    tick();
    core_ready_i = 1'b0;
    check("start_width", startxSO, 0);
    nbad = 0;
    for (int i = 0; i < delay; i++) begin
      if (startxSO || done_o || !busy_o) nbad++;
      go_i = (i == 0);
      tick();
    end
    go_i         = 1'b0;
    core_ready_i = 1'b1;
    check("wait_quiet", nbad, 0);
    tick();
    check("done_pulse", done_o, 1);
    check("busy_done", busy_o, 1);
    core_ready_i = 1'b0;
    tick();
    check("done_clear", done_o, 0);
    check("busy_idle", busy_o, 0);
    check("serial_idle", {keyxSO, noncexSO, adxSO, dataxSO, startxSO}, 0);
    check("decrypt_hold", decryptxSO, dec);
  endtask

  initial begin
    tbl[0] = '{128'h000102030405060708090A0B0C0D0E0F,
               128'hF0E1D2C3B4A5968778695A4B3C2D1E0F,
               128'h0123456789ABCDEFFEDCBA9876543210,
               128'h80000000000000000000000000000001,
               1'b0, 50, 1'b0};
    tbl[1] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
               128'h00000000000000000000000000000000,
               128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5,
               128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A,
               1'b1, 0, 1'b1};

    rst = 1'b1; wr_en_i = 1'b0; wr_sel_i = '0; wr_idx_i = '0; wr_data_i = '0;
    go_i = 1'b0; decrypt_i = 1'b0; core_ready_i = 1'b0;
    tick();
    check("reset_outputs", {keyxSO, noncexSO, adxSO, dataxSO, startxSO, decryptxSO,
                            busy_o, done_o, wr_err_o}, 0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", {busy_o, done_o, startxSO, decryptxSO}, 0);

    for (int v = 0; v < 2; v++) begin
      load(tbl[v].key, tbl[v].nonce, tbl[v].ad, tbl[v].data);
      check("wr_err_idle", wr_err_o, 0);
      do_run(tbl[v].dec, tbl[v].delay, tbl[v].early, -1, 1'b0, 32'h0, ck, cn, ca, cd);
      check("tbl_key", ck, tbl[v].key);
      check("tbl_nonce", cn, tbl[v].nonce);
      check("tbl_ad", ca, tbl[v].ad);
      check("tbl_data", cd, tbl[v].data);
    end

`ifdef ASCON_LOADER_KEY_WIPE_EN
    kexp = '0;
`else
    kexp = tbl[1].key;
`endif

    // Rejected write while shifting, without reloading.
    do_run(1'b1, 2, 1'b0, 40, 1'b0, 32'h0, pk, pn, pa, pd);
    check("err_run_key", pk, kexp);
    check("err_run_data", pd, tbl[1].data);
    check("err_run_ad", pa, tbl[1].ad);

    // Back-to-back repeat: identical streams, rejected write left no trace.
    do_run(1'b0, 1, 1'b0, -1, 1'b0, 32'h0, ck, cn, ca, cd);
    check("repeat_key", ck, pk);
    check("repeat_nonce", cn, pn);
    check("repeat_ad", ca, pa);
    check("repeat_data", cd, tbl[1].data);

    // Write data word 0 in the same cycle as go.
    do_run(1'b1, 3, 1'b0, -1, 1'b1, 32'hCAFEF00D, ck, cn, ca, cd);
    pd = tbl[1].data;
    check("same_cycle_data", cd, {32'hCAFEF00D, pd[95:0]});
    check("same_cycle_ad", ca, tbl[1].ad);
    check("same_cycle_key", ck, kexp);

    // Reset in the middle of SHIFT.
    go_i = 1'b1; decrypt_i = 1'b1;
    tick();
    go_i = 1'b0;
    repeat (60) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {keyxSO, noncexSO, adxSO, dataxSO, startxSO, decryptxSO,
                              busy_o, done_o, wr_err_o}, 0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o || busy_o || startxSO) bad++;
      tick();
    end
    check("rst_no_done", bad, 0);
    do_run(1'b0, 1, 1'b0, -1, 1'b0, 32'h0, ck, cn, ca, cd);
    check("zero_stream", {ck | cn | ca | cd}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
